uart_mem_cmd: RTL and testbench

- Byte-level command engine between one uart channel (rx valid/data, tx send/data) and a single-port synchronous word memory (SB_SPRAM256KA or equivalent).
- Replaces the fixed init-write/periodic-read sequencer with a host-driven protocol: single write, single read, burst read and block fill.
- Parametrised in address width, data width, memory read latency and inter-byte timeout.
- Sits in the top level on the 40 MHz PLL clock. It is the load/unload path for image data consumed by the jpeg lifting lanes.

---
 rtl/uart_mem_cmd_pkg.sv | 33 +++
 rtl/uart_mem_txser.sv | 68 ++++++
 rtl/uart_mem_cmd.sv | 204 ++++++++++++++++++++
 tb/tb_uart_mem_cmd.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_cmd_pkg.sv
// Shared constants for the uart memory command engine: opcodes, reply
// bytes, FSM state encoding and sticky error bit positions.
package uart_mem_cmd_pkg;

    // Host opcodes
    localparam logic [7:0] OP_W = 8'h57;   // single write
    localparam logic [7:0] OP_R = 8'h52;   // single read
    localparam logic [7:0] OP_B = 8'h42;   // burst read
    localparam logic [7:0] OP_F = 8'h46;   // block fill

    // Status replies
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    // Main FSM states. TX covers the whole serialiser handshake; the
    // serialiser itself owns the send/wait-for-busy sub-sequence.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARG     = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_TX      = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    // Sticky error flag positions
    localparam int ERR_OP  = 0;   // unknown opcode
    localparam int ERR_OVR = 1;   // byte arrived while not accepting
    localparam int ERR_TO  = 2;   // inter-byte timeout inside a command

    function automatic logic op_valid(input logic [7:0] b);
        return (b == OP_W) || (b == OP_R) || (b == OP_B) || (b == OP_F);
    endfunction

endpackage

// File: rtl/uart_mem_txser.sv
// Byte serialiser: takes a word plus a byte count and pushes the bytes out
// MSB first over the tx_send/tx_busy handshake, pulsing done after the last
// byte has left the transmitter.
module uart_mem_txser #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic [7:0]        nbytes,
    input  logic              tx_busy,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    output logic              done
);

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_SEND = 2'd1;
    localparam logic [1:0] T_WAIT = 2'd2;

    logic [1:0]        st;
    logic [DATA_W-1:0] sh;
    logic [7:0]        left;

    // The current byte is always the top of the shift register, so it only
    // moves while the transmitter is idle and stays put while tx_busy is high.
    assign tx_data = sh[DATA_W-1 -: 8];
    assign tx_send = (st == T_SEND) && !tx_busy;

    // Send one byte, wait for the transmitter to drain, repeat until empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st   <= T_IDLE;
            sh   <= '0;
            left <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                T_IDLE: begin
                    if (load) begin
                        sh   <= word;
                        left <= nbytes;
                        st   <= T_SEND;
                    end
                end
                T_SEND: begin
                    if (!tx_busy) st <= T_WAIT;
                end
                T_WAIT: begin
                    if (!tx_busy) begin
                        if (left == 8'd1) begin
                            done <= 1'b1;
                            st   <= T_IDLE;
                        end else begin
                            left <= left - 8'd1;
                            sh   <= sh << 8;
                            st   <= T_SEND;
                        end
                    end
                end
                default: st <= T_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mem_cmd.sv
// Host-driven command engine between a byte uart and a single-port word
// memory: single write, single read, burst read and block fill, with
// sticky error flags for bad opcodes, overruns and inter-byte timeouts.
module uart_mem_cmd
    import uart_mem_cmd_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 16,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 400000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [2:0]        err
);

    localparam int AB = (ADDR_W + 7) / 8;
    localparam int DB = DATA_W / 8;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [2:0]    st;
    logic [7:0]    op;
    logic [7:0]    bcnt;      // argument byte index within the command
    logic [8:0]    cnt;       // words left to write or read (1..256)
    logic [2:0]    rdc;       // read latency counter
    logic [TW-1:0] tcnt;      // idle cycles since the last argument byte
    logic          resp;      // TX is carrying a status byte, not data
    logic [7:0]    status;
    logic [7:0]    arg_last;
    logic          has_cnt;
    logic          expire;

    logic              ser_load;
    logic [DATA_W-1:0] ser_word;
    logic [7:0]        ser_nbytes;
    logic              ser_done;

    assign busy    = (st != S_IDLE);
    assign has_cnt = (op == OP_B) || (op == OP_F);
    assign expire  = (st == S_ARG) && (tcnt == TO_LAST);

    // Serialiser is fed either a status byte (top-aligned) or the read word
    // once the memory latency has elapsed.
    assign ser_load   = (st == S_RESP) || ((st == S_RD_WAIT) && (rdc == 3'(RD_LAT)));
    assign ser_word   = (st == S_RESP) ? (DATA_W'(status) << (DATA_W - 8)) : mem_rdata;
    assign ser_nbytes = (st == S_RESP) ? 8'd1 : 8'(DB);

    // Index of the final argument byte for the opcode being collected.
    always_comb begin
        arg_last = 8'(AB - 1);
        case (op)
            OP_W:    arg_last = 8'(AB + DB - 1);
            OP_B:    arg_last = 8'(AB);
            OP_F:    arg_last = 8'(AB + DB);
            default: arg_last = 8'(AB - 1);
        endcase
    end

    // Command decode, argument collection, memory sequencing and error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            op        <= '0;
            bcnt      <= '0;
            cnt       <= '0;
            rdc       <= '0;
            tcnt      <= '0;
            resp      <= 1'b0;
            status    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            err       <= '0;
        end else begin
            // Bytes are only accepted while decoding; anything else is lost,
            // including a byte that collides with the timeout.
            if (rx_valid && (!((st == S_IDLE) || (st == S_ARG)) || expire))
                err[ERR_OVR] <= 1'b1;

            case (st)
                S_IDLE: begin
                    bcnt <= '0;
                    tcnt <= '0;
                    resp <= 1'b0;
                    if (rx_valid) begin
                        op <= rx_data;
                        if (op_valid(rx_data)) begin
                            st <= S_ARG;
                        end else begin
                            err[ERR_OP] <= 1'b1;
                            status      <= NAK;
                            st          <= S_RESP;
                        end
                    end
                end

                S_ARG: begin
                    if (expire) begin
                        err[ERR_TO] <= 1'b1;
                        status      <= NAK;
                        st          <= S_RESP;
                    end else if (rx_valid) begin
                        tcnt <= '0;
                        // Shifting MSB-first into the register also masks
                        // the address to ADDR_W bits.
                        if (bcnt < 8'(AB))
                            mem_addr <= ADDR_W'({mem_addr, rx_data});
                        else if (has_cnt && (bcnt == 8'(AB)))
                            cnt <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        else
                            mem_wdata <= DATA_W'({mem_wdata, rx_data});

                        if (bcnt == arg_last) begin
                            case (op)
                                OP_W: begin
                                    cnt      <= 9'd1;
                                    mem_wren <= 1'b1;
                                    st       <= S_WRITE;
                                end
                                OP_F: begin
                                    mem_wren <= 1'b1;
                                    st       <= S_WRITE;
                                end
                                OP_R: begin
                                    cnt <= 9'd1;
                                    rdc <= '0;
                                    st  <= S_RD_WAIT;
                                end
                                default: begin
                                    rdc <= '0;
                                    st  <= S_RD_WAIT;
                                end
                            endcase
                        end else begin
                            bcnt <= bcnt + 8'd1;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                S_WRITE: begin
                    cnt <= cnt - 9'd1;
                    if (cnt == 9'd1) begin
                        mem_wren <= 1'b0;
                        status   <= ACK;
                        st       <= S_RESP;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end

                S_RD_WAIT: begin
                    if (rdc == 3'(RD_LAT)) st <= S_TX;
                    else                   rdc <= rdc + 3'd1;
                end

                S_TX: begin
                    if (ser_done) begin
                        if (resp || (cnt == 9'd1)) begin
                            st <= S_IDLE;
                        end else begin
                            cnt      <= cnt - 9'd1;
                            mem_addr <= mem_addr + ADDR_W'(1);
                            rdc      <= '0;
                            st       <= S_RD_WAIT;
                        end
                    end
                end

                S_RESP: begin
                    resp <= 1'b1;
                    st   <= S_TX;
                end

                default: st <= S_IDLE;
            endcase
        end
    end

    uart_mem_txser #(.DATA_W(DATA_W)) u_txser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ser_load),
        .word    (ser_word),
        .nbytes  (ser_nbytes),
        .tx_busy (tx_busy),
        .tx_send (tx_send),
        .tx_data (tx_data),
        .done    (ser_done)
    );

endmodule

// File: tb/tb_uart_mem_cmd.sv
// Bench for uart_mem_cmd: table vectors, directed corner sequences and
// randomized commands checked against a byte-stream reference model.
module tb_uart_mem_cmd;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;
    localparam int TO_CYC = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              tx_send;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic [2:0]        err;

    always #5 clk = ~clk;

    uart_mem_cmd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_send(tx_send), .tx_data(tx_data), .tx_busy(tx_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    // Memory and uart transmitter models
    bit [15:0]  dmem [16384];
    bit [15:0]  rpipe [RD_LAT];
    logic [7:0] tx_q[$];
    logic [29:0] wr_q[$];
    int         bcnt_tx = 0;
    int         viol = 0;

    assign mem_rdata = rpipe[RD_LAT-1];

    always @(posedge clk) begin
        if (mem_wren) begin
            dmem[mem_addr] <= mem_wdata;
            wr_q.push_back({mem_addr, mem_wdata});
        end
        rpipe[0] <= dmem[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    always @(posedge clk) begin
        if (tx_send) begin
            if (tx_busy) viol <= viol + 1;
            tx_q.push_back(tx_data);
            tx_busy <= 1'b1;
            bcnt_tx <= $urandom_range(1, 4);
        end else if (tx_busy) begin
            if (bcnt_tx <= 1) tx_busy <= 1'b0;
            bcnt_tx <= bcnt_tx - 1;
        end
    end

    // Reference model state
    bit [15:0]   rmem [16384];
    logic [7:0]  cmdq[$];
    logic [7:0]  etx[$];
    logic [29:0] ewr[$];
    logic [2:0]  eerr = 3'b000;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Predict replies and writes for one complete command in cmdq.
    task automatic model_run();
        int a, n, x;
        logic [15:0] d;
        etx.delete();
        ewr.delete();
        a = 0;
        if (cmdq.size() >= 3) a = {cmdq[1], cmdq[2]} % 16384;
        case (cmdq[0])
            8'h57: begin
                d = {cmdq[3], cmdq[4]};
                rmem[a] = d;
                ewr.push_back({a[13:0], d});
                etx.push_back(8'h06);
            end
            8'h52: begin
                etx.push_back(rmem[a][15:8]);
                etx.push_back(rmem[a][7:0]);
            end
            8'h42: begin
                n = (cmdq[3] == 0) ? 256 : int'(cmdq[3]);
                for (int i = 0; i < n; i++) begin
                    x = (a + i) % 16384;
                    etx.push_back(rmem[x][15:8]);
                    etx.push_back(rmem[x][7:0]);
                end
            end
            8'h46: begin
                n = (cmdq[3] == 0) ? 256 : int'(cmdq[3]);
                d = {cmdq[4], cmdq[5]};
                for (int i = 0; i < n; i++) begin
                    x = (a + i) % 16384;
                    rmem[x] = d;
                    ewr.push_back({x[13:0], d});
                end
                etx.push_back(8'h06);
            end
            default: begin
                etx.push_back(8'h15);
                eerr[0] = 1'b1;
            end
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd();
        foreach (cmdq[i]) begin
            send_byte(cmdq[i]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || tx_busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy || tx_busy) chk({name, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic compare_all(input string name);
        chk({name, "_ntx"}, tx_q.size(), etx.size());
        for (int i = 0; i < etx.size() && i < tx_q.size(); i++) chk({name, "_txbyte"}, tx_q[i], etx[i]);
        chk({name, "_nwr"}, wr_q.size(), ewr.size());
        for (int i = 0; i < ewr.size() && i < wr_q.size(); i++) chk({name, "_write"}, wr_q[i], ewr[i]);
        chk({name, "_err"}, err, eerr);
        chk({name, "_busy"}, busy, 0);
    endtask

    task automatic clear_obs();
        tx_q.delete();
        wr_q.delete();
    endtask

    typedef struct {
        logic [47:0] cmd;
        int          clen;
        logic [47:0] tx;
        int          tlen;
        logic [2:0]  err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{48'h570005ABCD00, 5, 48'h060000000000, 1, 3'b000};
        vecs[1] = '{48'h520005000000, 3, 48'hABCD00000000, 2, 3'b000};
        vecs[2] = '{48'h463FFE031234, 6, 48'h060000000000, 1, 3'b000};
        vecs[3] = '{48'h423FFE030000, 4, 48'h123412341234, 6, 3'b000};
        vecs[4] = '{48'h990000000000, 1, 48'h150000000000, 1, 3'b001};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_send", tx_send, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_txdata", tx_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors from the test plan
        for (int v = 0; v < 5; v++) begin
            logic [47:0] c, t;
            c = vecs[v].cmd;
            t = vecs[v].tx;
            cmdq.delete();
            for (int i = 0; i < vecs[v].clen; i++) cmdq.push_back(c[47-8*i -: 8]);
            model_run();
            etx.delete();
            for (int i = 0; i < vecs[v].tlen; i++) etx.push_back(t[47-8*i -: 8]);
            eerr = vecs[v].err;
            clear_obs();
            send_cmd();
            wait_idle("vec");
            compare_all($sformatf("vec%0d", v));
        end

        // W: write enable lands exactly one cycle after the last data byte
        cmdq = '{8'h57, 8'h00, 8'h07, 8'h11, 8'h22};
        model_run();
        clear_obs();
        for (int i = 0; i < 4; i++) send_byte(cmdq[i]);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h22;
        @(negedge clk);
        chk("w_lat_wren", mem_wren, 1);
        chk("w_lat_addr", mem_addr, 7);
        chk("w_lat_data", mem_wdata, 16'h1122);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("w_lat_wren_off", mem_wren, 0);
        wait_idle("w_lat");
        compare_all("w_lat");

        // R: first tx_send within RD_LAT+2 cycles of the last address byte
        cmdq = '{8'h52, 8'h00, 8'h07};
        model_run();
        clear_obs();
        send_byte(8'h52);
        send_byte(8'h00);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h07;
        @(negedge clk);
        rx_valid = 1'b0;
        n = 1;
        while (!tx_send && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("r_lat_within", (n <= RD_LAT + 2) ? 32'd1 : 32'd0, 32'd1);
        wait_idle("r_lat");
        compare_all("r_lat");

        // Randomized commands against the model
        for (int t = 0; t < 30; t++) begin
            int sel;
            logic [7:0] hi, lo, b;
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) begin
                hi = 8'h3F | 8'($urandom_range(0, 3) << 6);
                lo = 8'($urandom_range(8'hFA, 8'hFF));
            end else begin
                hi = 8'($urandom);
                lo = 8'($urandom);
            end
            cmdq.delete();
            if (sel <= 2)
                cmdq = '{8'h57, hi, lo, 8'($urandom), 8'($urandom)};
            else if (sel <= 4)
                cmdq = '{8'h52, hi, lo};
            else if (sel <= 6)
                cmdq = '{8'h42, hi, lo, 8'($urandom_range(1, 6))};
            else if (sel <= 8)
                cmdq = '{8'h46, hi, lo, 8'($urandom_range(1, 6)), 8'($urandom), 8'($urandom)};
            else begin
                b = 8'($urandom);
                while (b == 8'h57 || b == 8'h52 || b == 8'h42 || b == 8'h46) b = 8'($urandom);
                cmdq = '{b};
            end
            model_run();
            clear_obs();
            send_cmd();
            wait_idle("rand");
            compare_all("rand");
        end

        // Burst with count byte 0 means 256 words, crossing the top address
        cmdq = '{8'h42, 8'h3F, 8'h80, 8'h00};
        model_run();
        clear_obs();
        send_cmd();
        wait_idle("b256");
        compare_all("b256");

        // Overrun: a byte during a 4-word burst is dropped and flagged
        cmdq = '{8'h42, 8'h3F, 8'hFE, 8'h04};
        model_run();
        eerr[1] = 1'b1;
        clear_obs();
        send_cmd();
        n = 0;
        while (tx_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ovr_tx_started", (tx_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        send_byte(8'h52);
        chk("ovr_flag", err[1], 1);
        wait_idle("ovr");
        compare_all("ovr");

        // Timeout: partial command then silence
        clear_obs();
        send_byte(8'h57);
        send_byte(8'h00);
        repeat (94) @(negedge clk);
        chk("to_early", err[2], 0);
        repeat (10) @(negedge clk);
        chk("to_flag", err[2], 1);
        eerr[2] = 1'b1;
        etx = '{8'h15};
        ewr.delete();
        wait_idle("to");
        compare_all("to");
        cmdq = '{8'h57, 8'h00, 8'h09, 8'h55, 8'h66};
        model_run();
        clear_obs();
        send_cmd();
        wait_idle("to_after");
        compare_all("to_after");

        // Reset in the middle of a 200-word fill
        cmdq = '{8'h46, 8'h01, 8'h00, 8'hC8, 8'hAA, 8'h55};
        send_cmd();
        repeat (30) @(negedge clk);
        chk("fill_active", mem_wren, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_wren", mem_wren, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_send", tx_send, 0);
        chk("mid_rst_txdata", tx_data, 0);
        rst_n = 1'b1;
        clear_obs();
        repeat (300) @(negedge clk);
        chk("post_rst_writes", wr_q.size(), 0);
        chk("post_rst_tx", tx_q.size(), 0);
        chk("post_rst_busy", busy, 0);

        chk("send_while_busy", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
